// File: rtl/uart_fmt_pkg.sv
// Shared types and constants for the UART report formatter.
// Frame ids, FSM states, ASCII codes, frame lengths and saturation limits.
// Imported by uart_report_fmt and bin_to_dec3.
package uart_fmt_pkg;

  typedef enum logic [1:0] {FR_TIME, FR_DIST, FR_ENV} frame_e;
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND} state_e;

  // Command bytes that request a time report ('T' and 't').
  localparam logic [7:0] CMD_TIME    = 8'h54;
  localparam logic [7:0] CMD_TIME_LC = 8'h74;

  localparam logic [9:0] DIST_MAX    = 10'd999;
  localparam logic [9:0] TWO_DIG_MAX = 10'd99;

  localparam logic [7:0] A_CR    = 8'h0D;
  localparam logic [7:0] A_LF    = 8'h0A;
  localparam logic [7:0] A_EQ    = 8'h3D;
  localparam logic [7:0] A_COLON = 8'h3A;
  localparam logic [7:0] A_SPACE = 8'h20;
  localparam logic [7:0] A_ZERO  = 8'h30;
  localparam logic [7:0] A_T     = 8'h54;
  localparam logic [7:0] A_D     = 8'h44;
  localparam logic [7:0] A_H     = 8'h48;

  localparam logic [3:0] LEN_TIME = 4'd12;
  localparam logic [3:0] LEN_DIST = 4'd7;
  localparam logic [3:0] LEN_ENV  = 4'd11;

  function automatic logic [7:0] ascii_dig(input logic [3:0] d);
    return A_ZERO + {4'h0, d};
  endfunction

endpackage

// File: rtl/bin_to_dec3.sv
// Purpose: combinational binary (10 bit) to three BCD digits, saturating at 99 or 999.
// Latency: combinational, zero cycles.
// Ports: i_bin value, i_two_digit selects 99 saturation; o_d2/o_d1/o_d0 hundreds/tens/ones.
module bin_to_dec3
  import uart_fmt_pkg::*;
(
  input  logic [9:0] i_bin,
  input  logic       i_two_digit,
  output logic [3:0] o_d2,
  output logic [3:0] o_d1,
  output logic [3:0] o_d0
);

  logic [9:0] w_max;
  logic [9:0] w_val;
  logic [9:0] w_rem;
  logic [3:0] w_ones;

  // Digit extraction by comparison against multiples of 100 and 10; the
  // largest multiple not exceeding the value wins in each loop.
  always_comb begin
    w_max = i_two_digit ? TWO_DIG_MAX : DIST_MAX;
    w_val = (i_bin > w_max) ? w_max : i_bin;
    o_d2  = 4'd0;
    w_rem = w_val;
    for (int k = 1; k <= 9; k++) begin
      if (w_val >= 10'(k * 100)) begin
        o_d2  = 4'(k);
        w_rem = w_val - 10'(k * 100);
      end
    end
    o_d1   = 4'd0;
    w_ones = 4'(w_rem);
    for (int k = 1; k <= 9; k++) begin
      if (w_rem >= 10'(k * 10)) begin
        o_d1   = 4'(k);
        w_ones = 4'(w_rem - 10'(k * 10));
      end
    end
    o_d0 = w_ones;
  end

endmodule

// File: rtl/uart_report_fmt.sv
// Purpose: turns time commands and sensor-done pulses into ASCII report lines pushed into the UART TX FIFO.
// Latency: event sampled at edge N -> LOAD from N, first registered push after edge N+2; one idle cycle between frames.
// Backpressure: no byte is pushed at an edge where i_fifo_full is high; the byte index holds until space frees.
// Ports: i_rx_* command bytes, i_sr_done/i_dht_done triggers, i_hour..i_temp live values,
//        i_fifo_full from the FIFO; o_tx_push/o_tx_byte registered FIFO write, o_busy while a frame is active.
module uart_report_fmt
  import uart_fmt_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_rx_data,
  input  logic       i_rx_valid,
  input  logic       i_sr_done,
  input  logic       i_dht_done,
  input  logic [4:0] i_hour,
  input  logic [5:0] i_min,
  input  logic [5:0] i_sec,
  input  logic [9:0] i_dist,
  input  logic [7:0] i_humid,
  input  logic [7:0] i_temp,
  input  logic       i_fifo_full,
  output logic       o_tx_push,
  output logic [7:0] o_tx_byte,
  output logic       o_busy
);

  state_e     r_state, w_state_nxt;
  frame_e     r_frame, w_sel;
  logic       r_pend_t, r_pend_d, r_pend_e;
  logic [3:0] r_idx, r_last;
  logic [4:0] r_hour;
  logic [5:0] r_min, r_sec;
  logic [9:0] r_dist;
  logic [7:0] r_humid, r_temp;
  logic       r_tx_push;
  logic [7:0] r_tx_byte;

  logic       w_set_t, w_any, w_load, w_push;
  logic [9:0] w_bin;
  logic       w_two;
  logic [3:0] w_d2, w_d1, w_d0;
  logic [7:0] w_byte;

  assign w_set_t = i_rx_valid && ((i_rx_data == CMD_TIME) || (i_rx_data == CMD_TIME_LC));
  // Includes this cycle's events so a trigger goes straight to LOAD on the edge that latches it.
  assign w_any   = r_pend_t | r_pend_d | r_pend_e | w_set_t | i_sr_done | i_dht_done;
  assign w_load  = (r_state == S_LOAD);
  assign w_push  = (r_state == S_SEND) && !i_fifo_full;
  assign w_sel   = r_pend_t ? FR_TIME : (r_pend_d ? FR_DIST : FR_ENV);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_any) w_state_nxt = S_LOAD;
      S_LOAD: w_state_nxt = S_SEND;
      S_SEND: if (w_push && (r_idx == r_last)) w_state_nxt = w_any ? S_LOAD : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // One shared converter; the field feeding it follows the byte being emitted.
  bin_to_dec3 u_b2d (
    .i_bin      (w_bin),
    .i_two_digit(w_two),
    .o_d2       (w_d2),
    .o_d1       (w_d1),
    .o_d0       (w_d0)
  );

  always_comb begin
    w_bin  = 10'd0;
    w_two  = 1'b1;
    w_byte = A_LF;
    case (r_frame)
      FR_TIME: begin
        if (r_idx < 4'd4)      w_bin = {5'd0, r_hour};
        else if (r_idx < 4'd7) w_bin = {4'd0, r_min};
        else                   w_bin = {4'd0, r_sec};
        case (r_idx)
          4'd0:             w_byte = A_T;
          4'd1:             w_byte = A_EQ;
          4'd2, 4'd5, 4'd8: w_byte = ascii_dig(w_d1);
          4'd3, 4'd6, 4'd9: w_byte = ascii_dig(w_d0);
          4'd4, 4'd7:       w_byte = A_COLON;
          4'd10:            w_byte = A_CR;
          default:          w_byte = A_LF;
        endcase
      end
      FR_DIST: begin
        w_bin = r_dist;
        w_two = 1'b0;
        case (r_idx)
          4'd0:    w_byte = A_D;
          4'd1:    w_byte = A_EQ;
          4'd2:    w_byte = ascii_dig(w_d2);
          4'd3:    w_byte = ascii_dig(w_d1);
          4'd4:    w_byte = ascii_dig(w_d0);
          4'd5:    w_byte = A_CR;
          default: w_byte = A_LF;
        endcase
      end
      default: begin
        w_bin = (r_idx < 4'd5) ? {2'd0, r_humid} : {2'd0, r_temp};
        case (r_idx)
          4'd0:       w_byte = A_H;
          4'd1, 4'd6: w_byte = A_EQ;
          4'd2, 4'd7: w_byte = ascii_dig(w_d1);
          4'd3, 4'd8: w_byte = ascii_dig(w_d0);
          4'd4:       w_byte = A_SPACE;
          4'd5:       w_byte = A_T;
          4'd9:       w_byte = A_CR;
          default:    w_byte = A_LF;
        endcase
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_frame   <= FR_TIME;
      r_pend_t  <= 1'b0;
      r_pend_d  <= 1'b0;
      r_pend_e  <= 1'b0;
      r_idx     <= 4'd0;
      r_last    <= 4'd0;
      r_hour    <= 5'd0;
      r_min     <= 6'd0;
      r_sec     <= 6'd0;
      r_dist    <= 10'd0;
      r_humid   <= 8'd0;
      r_temp    <= 8'd0;
      r_tx_push <= 1'b0;
      r_tx_byte <= 8'h00;
    end else begin
      r_state   <= w_state_nxt;
      // A new event in the same cycle as the LOAD clear keeps the flag set.
      r_pend_t  <= w_set_t    | (r_pend_t & ~(w_load & (w_sel == FR_TIME)));
      r_pend_d  <= i_sr_done  | (r_pend_d & ~(w_load & (w_sel == FR_DIST)));
      r_pend_e  <= i_dht_done | (r_pend_e & ~(w_load & (w_sel == FR_ENV)));
      r_tx_push <= 1'b0;
      if (w_load) begin
        r_frame <= w_sel;
        r_idx   <= 4'd0;
        case (w_sel)
          FR_TIME: begin
            r_hour <= i_hour;
            r_min  <= i_min;
            r_sec  <= i_sec;
            r_last <= LEN_TIME - 4'd1;
          end
          FR_DIST: begin
            r_dist <= i_dist;
            r_last <= LEN_DIST - 4'd1;
          end
          default: begin
            r_humid <= i_humid;
            r_temp  <= i_temp;
            r_last  <= LEN_ENV - 4'd1;
          end
        endcase
      end
      if (w_push) begin
        r_tx_push <= 1'b1;
        r_tx_byte <= w_byte;
        r_idx     <= r_idx + 4'd1;
      end
    end
  end

  assign o_tx_push = r_tx_push;
  assign o_tx_byte = r_tx_byte;
  assign o_busy    = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_report_fmt.sv
// Purpose: directed self-checking bench for uart_report_fmt.
// Latency: inputs driven 2 ns after each rising edge, outputs sampled at the same point.
// Backpressure: fifo_full is driven directly by the scenarios.
module tb_uart_report_fmt;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       sr_done = 1'b0;
  logic       dht_done = 1'b0;
  logic [4:0] hour = 5'd0;
  logic [5:0] minute = 6'd0;
  logic [5:0] sec = 6'd0;
  logic [9:0] dist_cm = 10'd0;
  logic [7:0] humid = 8'd0;
  logic [7:0] temp = 8'd0;
  logic       fifo_full = 1'b0;
  logic       tx_push;
  logic [7:0] tx_byte;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int viol = 0;
  logic full_q = 1'b0;
  logic [7:0] got_b[$];
  int         got_c[$];

  uart_report_fmt dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_rx_data  (rx_data),
    .i_rx_valid (rx_valid),
    .i_sr_done  (sr_done),
    .i_dht_done (dht_done),
    .i_hour     (hour),
    .i_min      (minute),
    .i_sec      (sec),
    .i_dist     (dist_cm),
    .i_humid    (humid),
    .i_temp     (temp),
    .i_fifo_full(fifo_full),
    .o_tx_push  (tx_push),
    .o_tx_byte  (tx_byte),
    .o_busy     (busy)
  );

  always #5 clk = ~clk;

  // Records every pushed byte with the edge number that produced it.
  always @(posedge clk) begin
    cyc++;
    full_q = fifo_full;
    #1;
    if (tx_push === 1'b1) begin
      got_b.push_back(tx_byte);
      got_c.push_back(cyc);
      if (full_q) viol++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_mon();
    got_b.delete();
    got_c.delete();
  endtask

  task automatic wait_n(input int n, input int budget, output bit ok);
    for (int i = 0; i < budget; i++) begin
      if (got_b.size() >= n) break;
      tick();
    end
    ok = (got_b.size() >= n);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rx_data = 8'h54;
    rx_valid = 1'b1;
    tick();
    tick();
    checks++; if (tx_push !== 1'b0) begin errors++; $display("FAIL reset_push: got %b want 0", tx_push); end
    checks++; if (tx_byte !== 8'h00) begin errors++; $display("FAIL reset_byte: got %h want 00", tx_byte); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    rx_valid = 1'b0;
    rst_n = 1'b1;
    clear_mon();
    for (int i = 0; i < 6; i++) tick();
    checks++; if (got_b.size() !== 0) begin errors++; $display("FAIL reset_no_frame: got %0d bytes want 0", got_b.size()); end
  endtask

  task automatic test_time();
    string exp;
    logic [7:0] e;
    int t0;
    bit ok;
    exp = "T=09:05:42\015\012";
    hour = 5'd9; minute = 6'd5; sec = 6'd42;
    clear_mon();
    rx_data = 8'h54; rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    t0 = cyc;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL time_busy_load: got %b want 1", busy); end
    wait_n(12, 40, ok);
    checks++; if (!ok) begin errors++; $display("FAIL time_timeout: got %0d bytes want 12", got_b.size()); return; end
    checks++; if (got_c[0] !== t0 + 2) begin errors++; $display("FAIL time_latency: got edge %0d want %0d", got_c[0], t0 + 2); end
    checks++; if (got_c[11] !== t0 + 13) begin errors++; $display("FAIL time_contig: got edge %0d want %0d", got_c[11], t0 + 13); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL time_busy_end: got %b want 0", busy); end
    for (int i = 0; i < 12; i++) begin
      e = exp[i];
      checks++; if (got_b[i] !== e) begin errors++; $display("FAIL time_byte%0d: got %h want %h", i, got_b[i], e); end
    end
    for (int i = 0; i < 5; i++) tick();
    checks++; if (got_b.size() !== 12) begin errors++; $display("FAIL time_count: got %0d want 12", got_b.size()); end
  endtask

  task automatic test_dist_sat();
    string exp;
    logic [7:0] e;
    bit ok;
    exp = "D=999\015\012D=007\015\012";
    clear_mon();
    dist_cm = 10'd1023;
    sr_done = 1'b1; tick(); sr_done = 1'b0;
    wait_n(7, 30, ok);
    dist_cm = 10'd7;
    sr_done = 1'b1; tick(); sr_done = 1'b0;
    wait_n(14, 30, ok);
    checks++; if (!ok) begin errors++; $display("FAIL dist_timeout: got %0d bytes want 14", got_b.size()); return; end
    for (int i = 0; i < 14; i++) begin
      e = exp[i];
      checks++; if (got_b[i] !== e) begin errors++; $display("FAIL dist_byte%0d: got %h want %h", i, got_b[i], e); end
    end
  endtask

  task automatic test_backpressure();
    string exp;
    logic [7:0] e;
    int k;
    bit ok;
    exp = "H=55 T=99\015\012";
    clear_mon();
    humid = 8'd55; temp = 8'd120;
    dht_done = 1'b1; tick(); dht_done = 1'b0;
    wait_n(3, 30, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_timeout_pre: got %0d bytes want 3", got_b.size()); return; end
    k = cyc;
    fifo_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (tx_push !== 1'b0) begin errors++; $display("FAIL bp_push_while_full%0d: got %b want 0", i, tx_push); end
    end
    fifo_full = 1'b0;
    wait_n(11, 30, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_timeout: got %0d bytes want 11", got_b.size()); return; end
    checks++; if (got_c[3] !== k + 6) begin errors++; $display("FAIL bp_resume: got edge %0d want %0d", got_c[3], k + 6); end
    for (int i = 0; i < 11; i++) begin
      e = exp[i];
      checks++; if (got_b[i] !== e) begin errors++; $display("FAIL bp_byte%0d: got %h want %h", i, got_b[i], e); end
    end
    for (int i = 0; i < 5; i++) tick();
    checks++; if (got_b.size() !== 11) begin errors++; $display("FAIL bp_count: got %0d want 11", got_b.size()); end
    checks++; if (viol !== 0) begin errors++; $display("FAIL bp_full_violation: got %0d want 0", viol); end
  endtask

  task automatic test_simultaneous();
    string exp;
    logic [7:0] e;
    int t0;
    bit ok;
    exp = "T=23:59:00\015\012D=512\015\012H=08 T=00\015\012";
    clear_mon();
    hour = 5'd23; minute = 6'd59; sec = 6'd0;
    dist_cm = 10'd512; humid = 8'd8; temp = 8'd0;
    rx_data = 8'h54; rx_valid = 1'b1; sr_done = 1'b1; dht_done = 1'b1;
    tick();
    rx_valid = 1'b0; sr_done = 1'b0; dht_done = 1'b0;
    t0 = cyc;
    wait_n(30, 80, ok);
    checks++; if (!ok) begin errors++; $display("FAIL sim_timeout: got %0d bytes want 30", got_b.size()); return; end
    checks++; if (got_c[0] !== t0 + 2) begin errors++; $display("FAIL sim_latency: got %0d want %0d", got_c[0], t0 + 2); end
    checks++; if (got_c[12] !== got_c[11] + 2) begin errors++; $display("FAIL sim_gap1: got %0d want %0d", got_c[12], got_c[11] + 2); end
    checks++; if (got_c[19] !== got_c[18] + 2) begin errors++; $display("FAIL sim_gap2: got %0d want %0d", got_c[19], got_c[18] + 2); end
    for (int i = 0; i < 30; i++) begin
      e = exp[i];
      checks++; if (got_b[i] !== e) begin errors++; $display("FAIL sim_byte%0d: got %h want %h", i, got_b[i], e); end
    end
  endtask

  task automatic test_coalesce_snapshot();
    string exp;
    logic [7:0] e;
    bit ok;
    exp = "T=01:02:03\015\012D=100\015\012";
    clear_mon();
    hour = 5'd1; minute = 6'd2; sec = 6'd3; dist_cm = 10'd100;
    rx_data = 8'h74; rx_valid = 1'b1; tick(); rx_valid = 1'b0;
    wait_n(3, 20, ok);
    for (int i = 0; i < 3; i++) begin
      sr_done = 1'b1; tick(); sr_done = 1'b0; tick();
    end
    wait_n(13, 40, ok);
    dist_cm = 10'd200;
    wait_n(19, 40, ok);
    checks++; if (!ok) begin errors++; $display("FAIL coal_timeout: got %0d bytes want 19", got_b.size()); return; end
    for (int i = 0; i < 25; i++) tick();
    checks++; if (got_b.size() !== 19) begin errors++; $display("FAIL coal_count: got %0d want 19", got_b.size()); end
    for (int i = 0; i < 19; i++) begin
      e = exp[i];
      checks++; if (got_b[i] !== e) begin errors++; $display("FAIL coal_byte%0d: got %h want %h", i, got_b[i], e); end
    end
  endtask

  task automatic test_reset_mid();
    string exp;
    logic [7:0] e;
    bit ok;
    exp = "T=00:00:09\015\012";
    clear_mon();
    hour = 5'd12; minute = 6'd34; sec = 6'd56;
    rx_data = 8'h54; rx_valid = 1'b1; tick(); rx_valid = 1'b0;
    wait_n(4, 20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rmid_timeout_pre: got %0d bytes want 4", got_b.size()); return; end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++; if (tx_push !== 1'b0) begin errors++; $display("FAIL rmid_push: got %b want 0", tx_push); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b want 0", busy); end
    checks++; if (tx_byte !== 8'h00) begin errors++; $display("FAIL rmid_byte: got %h want 00", tx_byte); end
    for (int i = 0; i < 20; i++) tick();
    checks++; if (got_b.size() !== 4) begin errors++; $display("FAIL rmid_abandon: got %0d bytes want 4", got_b.size()); end
    clear_mon();
    hour = 5'd0; minute = 6'd0; sec = 6'd9;
    rx_data = 8'h74; rx_valid = 1'b1; tick(); rx_valid = 1'b0;
    wait_n(12, 40, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rmid_timeout: got %0d bytes want 12", got_b.size()); return; end
    for (int i = 0; i < 12; i++) begin
      e = exp[i];
      checks++; if (got_b[i] !== e) begin errors++; $display("FAIL rmid_byte%0d: got %h want %h", i, got_b[i], e); end
    end
  endtask

  initial begin
    test_reset();
    test_time();
    test_dist_sat();
    test_backpressure();
    test_simultaneous();
    test_coalesce_snapshot();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within 200000 ns");
    $fatal(1, "watchdog expired");
  end

endmodule
